// File: rtl/aftab_mtimer_if.sv
// Byte-wide aftab_core memory bus: level requests from the master, and a
// one-cycle acknowledge carrying read data back from the slave.
interface aftab_mtimer_if;
    logic        readMem;
    logic        writeMem;
    logic [31:0] addressBus;
    logic [7:0]  dataBusIn;
    logic [7:0]  dataBusOut;
    logic        memDataReady;

    modport master (
        output readMem, writeMem, addressBus, dataBusIn,
        input  dataBusOut, memDataReady
    );

    modport slave (
        input  readMem, writeMem, addressBus, dataBusIn,
        output dataBusOut, memDataReady
    );
endinterface

// File: rtl/aftab_mtimer.sv
// Memory-mapped machine timer: 64-bit mtime/mtimecmp behind a byte bus with
// snapshot reads of mtime, atomic mtimecmp update and a level interrupt.
module aftab_mtimer #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_F000,
    parameter int unsigned PRESCALE  = 1
) (
    input  logic          clk,
    input  logic          rst,
    aftab_mtimer_if.slave bus,
    output logic          machineTimerInterrupt
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESCALE_MAX = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACK,
        RELEASE
    } stateType;

    stateType      state;
    stateType      stateNext;

    logic [63:0]   mtime;
    logic [63:0]   mtimeNext;
    logic [63:0]   mtimecmp;
    logic [63:0]   shadow;
    logic [55:0]   staging;
    logic          en;
    logic          ie;
    logic [PW-1:0] prescaler;
    logic [7:0]    rdData;
    logic [7:0]    rdByte;

    logic          hit;
    logic          accept;
    logic          rdAccept;
    logic          wrAccept;
    logic          tick;
    logic [4:0]    offset;
    logic [5:0]    byteSel;

    assign offset   = bus.addressBus[4:0];
    assign byteSel  = {offset[2:0], 3'b000};
    assign hit      = (bus.addressBus[31:5] == BASE_ADDR[31:5]);
    assign accept   = (state == IDLE) && (bus.readMem ^ bus.writeMem) && hit;
    assign rdAccept = accept && bus.readMem;
    assign wrAccept = accept && bus.writeMem;
    assign tick     = en && (prescaler == PRESCALE_MAX);

    assign bus.memDataReady = (state == ACK);
    assign bus.dataBusOut   = (state == ACK) ? rdData : 8'h00;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= stateNext;
    end

    always_comb begin
        // NOTE: every always_comb output gets a default before any branch, so no path can infer a latch.
        stateNext = state;
        unique case (state)
            IDLE:    if (accept) stateNext = ACK;
            ACK:     stateNext = RELEASE;
            RELEASE: if (!bus.readMem && !bus.writeMem) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Offset 0 reads live mtime; bytes 1..7 come from the copy taken at that read.
    always_comb begin
        rdByte = 8'h00;
        case (offset[4:3])
            2'b00:   rdByte = (offset[2:0] == 3'd0) ? mtime[7:0] : shadow[byteSel +: 8];
            2'b01:   rdByte = mtimecmp[byteSel +: 8];
            2'b10:   if (offset[2:0] == 3'd0) rdByte = {6'b000000, ie, en};
            default: rdByte = 8'h00;
        endcase
    end

    // A byte write to mtime replaces the increment for that edge.
    always_comb begin
        mtimeNext = tick ? mtime + 64'd1 : mtime;
        if (wrAccept && (offset[4:3] == 2'b00)) begin
            mtimeNext = mtime;
            mtimeNext[byteSel +: 8] = bus.dataBusIn;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mtime                 <= 64'd0;
            mtimecmp              <= {64{1'b1}};
            shadow                <= 64'd0;
            staging               <= 56'd0;
            en                    <= 1'b0;
            ie                    <= 1'b0;
            prescaler             <= '0;
            rdData                <= 8'h00;
            machineTimerInterrupt <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            mtime                 <= mtimeNext;
            machineTimerInterrupt <= ie && (mtime >= mtimecmp);

            if (en) prescaler <= tick ? '0 : prescaler + PW'(1);

            if (rdAccept) begin
                rdData <= rdByte;
                if (offset == 5'h00) shadow <= mtime;
            end

            if (wrAccept) begin
                if (offset[4:3] == 2'b01) begin
                    if (offset[2:0] == 3'd7) begin
                        mtimecmp <= {bus.dataBusIn, staging};
                    end else begin
                        for (int i = 0; i < 7; i++) begin
                            if (offset[2:0] == 3'(i)) staging[i*8 +: 8] <= bus.dataBusIn;
                        end
                    end
                end
                if (offset == 5'h10) begin
                    en <= bus.dataBusIn[0];
                    ie <= bus.dataBusIn[1];
                    if (!bus.dataBusIn[0]) prescaler <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_aftab_mtimer.sv
// Directed bench for aftab_mtimer: two instances (PRESCALE 4 and 1) share
// identical bus stimulus so handshakes line up and only mtime rates differ.
module tb_aftab_mtimer;

    localparam logic [31:0] BASE = 32'h0000_F000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic mti0;
    logic mti1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   lastAck = 0;
    logic lastMti0 = 1'b0;
    logic lastMti1 = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aftab_mtimer_if bus0 ();
    aftab_mtimer_if bus1 ();

    assign bus1.readMem    = bus0.readMem;
    assign bus1.writeMem   = bus0.writeMem;
    assign bus1.addressBus = bus0.addressBus;
    assign bus1.dataBusIn  = bus0.dataBusIn;

    aftab_mtimer #(.BASE_ADDR(BASE), .PRESCALE(4)) dut0 (
        .clk                   (clk),
        .rst                   (rst),
        .bus                   (bus0),
        .machineTimerInterrupt (mti0)
    );

    aftab_mtimer #(.BASE_ADDR(BASE), .PRESCALE(1)) dut1 (
        .clk                   (clk),
        .rst                   (rst),
        .bus                   (bus1),
        .machineTimerInterrupt (mti1)
    );

    task automatic busAccess(input logic isWrite, input logic [7:0] off, input logic [7:0] wdata,
                             output logic [7:0] r0, output logic [7:0] r1);
        bit got;
        @(negedge clk);
        bus0.addressBus = BASE + 32'(off);
        bus0.dataBusIn  = wdata;
        bus0.readMem    = !isWrite;
        bus0.writeMem   = isWrite;
        got = 1'b0;
        r0  = 8'h00;
        r1  = 8'h00;
        for (int i = 0; i < 4 && !got; i++) begin
            @(negedge clk);
            if (bus0.memDataReady) begin
                got      = 1'b1;
                r0       = bus0.dataBusOut;
                r1       = bus1.dataBusOut;
                lastAck  = cyc;
                lastMti0 = mti0;
                lastMti1 = mti1;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL handshake off=%h write=%0b: memDataReady got 0, expected 1 within 4 cycles", off, isWrite);
        end
        bus0.readMem  = 1'b0;
        bus0.writeMem = 1'b0;
        @(negedge clk);
    endtask

    task automatic wr(input logic [7:0] off, input logic [7:0] data);
        logic [7:0] a;
        logic [7:0] b;
        busAccess(1'b1, off, data, a, b);
    endtask

    task automatic rd(input logic [7:0] off, output logic [7:0] r0, output logic [7:0] r1);
        busAccess(1'b0, off, 8'h00, r0, r1);
    endtask

    task automatic rd64(input logic [7:0] off, output logic [63:0] v0, output logic [63:0] v1);
        logic [7:0] a;
        logic [7:0] b;
        for (int i = 0; i < 8; i++) begin
            rd(off + 8'(i), a, b);
            v0[i*8 +: 8] = a;
            v1[i*8 +: 8] = b;
        end
    endtask

    task automatic test_reset();
        logic [63:0] v0;
        logic [63:0] v1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        checks++;
        if ({bus0.memDataReady, bus0.dataBusOut, mti0, mti1} !== 11'd0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b data=%h mti=%b%b, expected all 0",
                     bus0.memDataReady, bus0.dataBusOut, mti0, mti1);
        end
        rd64(8'h00, v0, v1);
        checks++;
        if (v0 !== 64'd0 || v1 !== 64'd0) begin
            errors++;
            $display("FAIL reset_mtime: got %h/%h, expected 0", v0, v1);
        end
        rd64(8'h08, v0, v1);
        checks++;
        if (v0 !== {64{1'b1}} || v1 !== {64{1'b1}}) begin
            errors++;
            $display("FAIL reset_mtimecmp: got %h/%h, expected all ones", v0, v1);
        end
    endtask

    task automatic test_counting();
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [63:0] got0;
        logic [63:0] got1;
        logic [63:0] exp0;
        logic [63:0] exp1;
        int          e;
        wr(8'h10, 8'h01);
        e = lastAck;
        repeat (40) @(negedge clk);
        rd(8'h00, b0, b1);
        exp0 = 64'((lastAck - e - 1) / 4);
        exp1 = 64'(lastAck - e - 1);
        got0[7:0] = b0;
        got1[7:0] = b1;
        checks++;
        if (b0 !== exp0[7:0] || b1 !== exp1[7:0]) begin
            errors++;
            $display("FAIL count_byte0: got %h/%h, expected %h/%h", b0, b1, exp0[7:0], exp1[7:0]);
        end
        // Let live mtime on the fast instance carry into byte 1 before reading the rest.
        repeat (300) @(negedge clk);
        for (int i = 1; i < 8; i++) begin
            rd(8'(i), b0, b1);
            got0[i*8 +: 8] = b0;
            got1[i*8 +: 8] = b1;
        end
        checks++;
        if (got0 !== exp0 || got1 !== exp1) begin
            errors++;
            $display("FAIL count_snapshot: got %h/%h, expected %h/%h", got0, got1, exp0, exp1);
        end
    endtask

    task automatic test_atomic_cmp();
        logic [63:0] v0;
        logic [63:0] v1;
        for (int i = 0; i < 7; i++) wr(8'h08 + 8'(i), (i == 0) ? 8'h20 : 8'h00);
        rd64(8'h08, v0, v1);
        checks++;
        if (v0 !== {64{1'b1}} || v1 !== {64{1'b1}}) begin
            errors++;
            $display("FAIL cmp_staged: got %h/%h, expected all ones", v0, v1);
        end
        wr(8'h0F, 8'h00);
        rd64(8'h08, v0, v1);
        checks++;
        if (v0 !== 64'h20 || v1 !== 64'h20) begin
            errors++;
            $display("FAIL cmp_commit: got %h/%h, expected 0x20", v0, v1);
        end
    endtask

    task automatic test_ctrl_reserved();
        logic [7:0] b0;
        logic [7:0] b1;
        wr(8'h10, 8'hFF);
        rd(8'h10, b0, b1);
        checks++;
        if (b0 !== 8'h03 || b1 !== 8'h03) begin
            errors++;
            $display("FAIL ctrl_mask: got %h/%h, expected 03", b0, b1);
        end
        wr(8'h11, 8'hAA);
        rd(8'h11, b0, b1);
        checks++;
        if (b0 !== 8'h00 || b1 !== 8'h00) begin
            errors++;
            $display("FAIL reserved_11: got %h/%h, expected 00", b0, b1);
        end
        rd(8'h1F, b0, b1);
        checks++;
        if (b0 !== 8'h00 || b1 !== 8'h00) begin
            errors++;
            $display("FAIL reserved_1f: got %h/%h, expected 00", b0, b1);
        end
        wr(8'h10, 8'h00);
        rd(8'h10, b0, b1);
        checks++;
        if (b0 !== 8'h00 || b1 !== 8'h00) begin
            errors++;
            $display("FAIL ctrl_clear: got %h/%h, expected 00", b0, b1);
        end
    endtask

    task automatic test_interrupt();
        int e;
        int w;
        int rise0;
        int rise1;
        wr(8'h10, 8'h00);
        for (int i = 0; i < 8; i++) wr(8'(i), 8'h00);
        wr(8'h10, 8'h03);
        e = lastAck;
        rise0 = -1;
        rise1 = -1;
        for (int i = 0; i < 200 && rise0 < 0; i++) begin
            @(negedge clk);
            if (mti0 && rise0 < 0) rise0 = cyc;
            if (mti1 && rise1 < 0) rise1 = cyc;
        end
        checks++;
        if (rise0 != e + 129) begin
            errors++;
            $display("FAIL irq_rise_ps4: rose at edge %0d, expected %0d", rise0 - e, 129);
        end
        checks++;
        if (rise1 != e + 33) begin
            errors++;
            $display("FAIL irq_rise_ps1: rose at edge %0d, expected %0d", rise1 - e, 33);
        end
        wr(8'h0F, 8'h01);
        w = lastAck;
        checks++;
        if (lastMti0 !== 1'b1 || lastMti1 !== 1'b1) begin
            errors++;
            $display("FAIL irq_hold_at_write: got %b%b at edge %0d, expected 11", lastMti0, lastMti1, w);
        end
        checks++;
        if (mti0 !== 1'b0 || mti1 !== 1'b0) begin
            errors++;
            $display("FAIL irq_drop: got %b%b one cycle after cmp raise, expected 00", mti0, mti1);
        end
    endtask

    task automatic test_wrap();
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [63:0] got0;
        logic [63:0] got1;
        logic [63:0] exp0;
        logic [63:0] exp1;
        int          e;
        wr(8'h10, 8'h00);
        for (int i = 0; i < 8; i++) wr(8'(i), 8'hFF);
        wr(8'h10, 8'h01);
        e = lastAck;
        rd(8'h00, b0, b1);
        exp0 = {64{1'b1}} + 64'((lastAck - e - 1) / 4);
        exp1 = {64{1'b1}} + 64'(lastAck - e - 1);
        got0[7:0] = b0;
        got1[7:0] = b1;
        for (int i = 1; i < 8; i++) begin
            rd(8'(i), b0, b1);
            got0[i*8 +: 8] = b0;
            got1[i*8 +: 8] = b1;
        end
        checks++;
        if (got1 !== exp1) begin
            errors++;
            $display("FAIL wrap_ps1: got %h, expected %h", got1, exp1);
        end
        checks++;
        if (got0 !== exp0) begin
            errors++;
            $display("FAIL wrap_ps4: got %h, expected %h", got0, exp0);
        end
        checks++;
        if (mti0 !== 1'b0 || mti1 !== 1'b0) begin
            errors++;
            $display("FAIL wrap_irq_masked: got %b%b, expected 00", mti0, mti1);
        end
    endtask

    task automatic test_protocol_corners();
        logic [7:0] b0;
        logic [7:0] b1;
        bit         seen;
        @(negedge clk);
        bus0.addressBus = BASE + 32'h10;
        bus0.dataBusIn  = 8'h00;
        bus0.readMem    = 1'b1;
        bus0.writeMem   = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (bus0.memDataReady || bus1.memDataReady) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL both_requests: memDataReady got 1, expected 0");
        end
        bus0.writeMem   = 1'b0;
        bus0.addressBus = BASE + 32'h20;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (bus0.memDataReady || bus0.dataBusOut != 8'h00) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL out_of_window_read: ready/data got nonzero, expected 0");
        end
        bus0.readMem = 1'b0;
        @(negedge clk);
        // Aliased write to the ctrl offset one window up must not touch ctrl.
        bus0.addressBus = BASE + 32'h30;
        bus0.writeMem   = 1'b1;
        repeat (3) @(negedge clk);
        bus0.writeMem = 1'b0;
        @(negedge clk);
        rd(8'h10, b0, b1);
        checks++;
        if (b0 !== 8'h01 || b1 !== 8'h01) begin
            errors++;
            $display("FAIL ignored_requests_ctrl: got %h/%h, expected 01", b0, b1);
        end
    endtask

    task automatic test_reset_mid_ack();
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [63:0] v0;
        logic [63:0] v1;
        @(negedge clk);
        bus0.addressBus = BASE + 32'h10;
        bus0.readMem    = 1'b1;
        @(negedge clk);
        checks++;
        if (bus0.memDataReady !== 1'b1) begin
            errors++;
            $display("FAIL mid_ack_setup: ready got %b, expected 1", bus0.memDataReady);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus0.memDataReady !== 1'b0 || bus1.memDataReady !== 1'b0 || bus0.dataBusOut !== 8'h00) begin
            errors++;
            $display("FAIL mid_ack_reset: ready=%b%b data=%h, expected 0",
                     bus0.memDataReady, bus1.memDataReady, bus0.dataBusOut);
        end
        bus0.readMem = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        rd(8'h10, b0, b1);
        checks++;
        if (b0 !== 8'h00 || b1 !== 8'h00) begin
            errors++;
            $display("FAIL mid_ack_ctrl: got %h/%h, expected 00", b0, b1);
        end
        rd64(8'h00, v0, v1);
        checks++;
        if (v0 !== 64'd0 || v1 !== 64'd0) begin
            errors++;
            $display("FAIL mid_ack_mtime: got %h/%h, expected 0", v0, v1);
        end
        rd64(8'h08, v0, v1);
        checks++;
        if (v0 !== {64{1'b1}} || v1 !== {64{1'b1}} || mti0 !== 1'b0 || mti1 !== 1'b0) begin
            errors++;
            $display("FAIL mid_ack_cmp_irq: cmp %h/%h irq %b%b, expected all ones and 00", v0, v1, mti0, mti1);
        end
    endtask

    initial begin
        bus0.readMem    = 1'b0;
        bus0.writeMem   = 1'b0;
        bus0.addressBus = 32'd0;
        bus0.dataBusIn  = 8'd0;
        test_reset();
        test_counting();
        test_atomic_cmp();
        test_ctrl_reserved();
        test_interrupt();
        test_wrap();
        test_protocol_corners();
        test_reset_mid_ack();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
